// File: rtl/alu_issue.sv
// Issue/sequencing wrapper around an external combinational ALU: latches one request,
// waits the op-dependent number of EXEC cycles, captures HI/LO and holds the response.
module alu_issue #(
  parameter int MULDIV_WAIT = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_y,
  input  logic [31:0] req_b,
  input  logic        req_incpc,
  input  logic        req_br,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        rsp_err,
  output logic [31:0] alu_y,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  output logic        alu_incpc,
  output logic        alu_br,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  output logic [31:0] hi_reg,
  output logic [31:0] lo_reg
);

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [1:0] {CL_ALU, CL_MULDIV, CL_MOVE, CL_ERR} class_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   y_q, b_q, rsp_hi_q, rsp_lo_q, hi_q, lo_q;
  logic [4:0]          op_q;
  logic                incpc_q, br_q, rsp_err_q;
  logic                accept, capture;
  class_e              cls;

  // An IncPC request always runs through the ALU, whatever the opcode says.
  function automatic class_e classify(input logic [4:0] op, input logic [DATA_W-1:0] b,
                                      input logic incpc);
    if (incpc) return CL_ALU;
    case (op) inside
      [5'b00000:5'b01110], 5'b10001, 5'b10010, 5'b10011, 5'b11100: return CL_ALU;
      OP_MUL:           return CL_MULDIV;
      OP_DIV:           return (b != '0) ? CL_MULDIV : CL_ERR;
      OP_MFHI, OP_MFLO: return CL_MOVE;
      default:          return CL_ERR;
    endcase
  endfunction

  assign cls     = classify(req_opcode, req_b, req_incpc);
  assign accept  = (state_q == IDLE) && req_valid;
  assign capture = (state_q == EXEC) && (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          case (cls)
            CL_ALU:    begin state_d = EXEC; cnt_d = 4'd0; end
            CL_MULDIV: begin state_d = EXEC; cnt_d = 4'(MULDIV_WAIT - 1); end
            default:   begin state_d = DONE; cnt_d = 4'd0; end
          endcase
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = 4'(cnt_q - 4'd1);
      end
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    alu_incpc = (state_q == EXEC) && incpc_q;
  end

  // Operand latch on accept, response capture on EXEC exit or direct-to-DONE ops
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      y_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      incpc_q   <= 1'b0;
      br_q      <= 1'b0;
      rsp_hi_q  <= '0;
      rsp_lo_q  <= '0;
      rsp_err_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        y_q     <= req_y;
        b_q     <= req_b;
        op_q    <= req_opcode;
        incpc_q <= req_incpc;
        br_q    <= req_br;
        if (cls == CL_MOVE) begin
          rsp_hi_q  <= '0;
          rsp_lo_q  <= (req_opcode == OP_MFHI) ? hi_q : lo_q;
          rsp_err_q <= 1'b0;
        end else if (cls == CL_ERR) begin
          rsp_hi_q  <= '0;
          rsp_lo_q  <= '0;
          rsp_err_q <= 1'b1;
        end
      end
      if (capture) begin
        rsp_hi_q  <= alu_hi;
        rsp_lo_q  <= alu_lo;
        rsp_err_q <= 1'b0;
        if (!incpc_q && (op_q == OP_MUL || op_q == OP_DIV)) begin
          hi_q <= alu_hi;
          lo_q <= alu_lo;
        end
      end
    end
  end

  assign alu_y      = y_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign alu_br     = br_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_lo     = rsp_lo_q;
  assign rsp_err    = rsp_err_q;
  assign hi_reg     = hi_q;
  assign lo_reg     = lo_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: vector table through a small ALU model, plus
// hand-written stall and reset-abort sequences.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid, req_ready, req_incpc, req_br;
  logic [4:0]  req_opcode, alu_opcode;
  logic [31:0] req_y, req_b;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_hi, rsp_lo, alu_y, alu_b, alu_hi, alu_lo, hi_reg, lo_reg;
  logic        alu_incpc, alu_br;
  logic [63:0] prod;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_issue #(.MULDIV_WAIT(4)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_y(req_y), .req_b(req_b), .req_incpc(req_incpc), .req_br(req_br),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_err(rsp_err), .alu_y(alu_y), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_incpc(alu_incpc), .alu_br(alu_br), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .hi_reg(hi_reg), .lo_reg(lo_reg)
  );

  // Behavioural ALU: IncPC adds 1 to B; mul gives a 64-bit product; div gives {rem, quot}.
  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    prod   = '0;
    if (alu_incpc) alu_lo = alu_b + 32'd1;
    else begin
      case (alu_opcode)
        5'b00100, 5'b11100: alu_lo = alu_y - alu_b;
        5'b01111: begin
          prod   = {32'd0, alu_y} * {32'd0, alu_b};
          alu_hi = prod[63:32];
          alu_lo = prod[31:0];
        end
        5'b10000: if (alu_b != 0) begin
          alu_lo = alu_y / alu_b;
          alu_hi = alu_y % alu_b;
        end
        default: alu_lo = alu_y + alu_b;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] y;
    logic [31:0] b;
    logic        incpc;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    logic [31:0] hreg;
    logic [31:0] lreg;
    int          ic_cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int ic;
    @(negedge clk);
    chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
    req_opcode = v.op; req_y = v.y; req_b = v.b; req_incpc = v.incpc; req_br = v.y[0];
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_y = 32'hDEADBEEF; req_b = 32'hCAFEF00D; req_opcode = 5'b11111; req_incpc = 1'b0;
    n = 0; ic = 0;
    while (!rsp_valid && n < 20) begin
      if (alu_incpc) ic++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"},  64'(n), 64'(v.lat));
    chk({tag, " incpc cycles"}, 64'(ic), 64'(v.ic_cyc));
    chk({tag, " rsp_hi"},  64'(rsp_hi), 64'(v.hi));
    chk({tag, " rsp_lo"},  64'(rsp_lo), 64'(v.lo));
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(v.err));
    chk({tag, " hi_reg"},  64'(hi_reg), 64'(v.hreg));
    chk({tag, " lo_reg"},  64'(lo_reg), 64'(v.lreg));
    chk({tag, " alu operands"}, {alu_y, alu_b}, {v.y, v.b});
    chk({tag, " alu_opcode/br/incpc"}, {59'd0, alu_opcode, alu_br, alu_incpc}, {59'd0, v.op, v.y[0], 1'b0});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " idle after release"}, {62'd0, rsp_valid, req_ready}, 64'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_incpc = 1'b0; req_br = 1'b0;
    req_opcode = '0; req_y = '0; req_b = '0;

    //          op        y             b            inc lat hi            lo            err hreg          lreg          ic
    vecs[0]  = '{5'b00011, 32'd5,        32'd7,        0, 1, 32'd0,        32'd12,       0, 32'd0,        32'd0,        0};
    vecs[1]  = '{5'b00100, 32'd10,       32'd3,        0, 1, 32'd0,        32'd7,        0, 32'd0,        32'd0,        0};
    vecs[2]  = '{5'b01111, 32'h00010000, 32'h00010000, 0, 4, 32'd1,        32'd0,        0, 32'd1,        32'd0,        0};
    vecs[3]  = '{5'b11000, 32'd0,        32'd0,        0, 0, 32'd0,        32'd1,        0, 32'd1,        32'd0,        0};
    vecs[4]  = '{5'b11001, 32'd0,        32'd0,        0, 0, 32'd0,        32'd0,        0, 32'd1,        32'd0,        0};
    vecs[5]  = '{5'b10000, 32'd100,      32'd0,        0, 0, 32'd0,        32'd0,        1, 32'd1,        32'd0,        0};
    vecs[6]  = '{5'b10000, 32'd100,      32'd7,        0, 4, 32'd2,        32'd14,       0, 32'd2,        32'd14,       0};
    vecs[7]  = '{5'b11001, 32'd0,        32'd0,        0, 0, 32'd0,        32'd14,       0, 32'd2,        32'd14,       0};
    vecs[8]  = '{5'b10100, 32'd3,        32'd4,        0, 0, 32'd0,        32'd0,        1, 32'd2,        32'd14,       0};
    vecs[9]  = '{5'b11111, 32'd3,        32'd4,        0, 0, 32'd0,        32'd0,        1, 32'd2,        32'd14,       0};
    vecs[10] = '{5'b11011, 32'd0,        32'h100,      1, 1, 32'd0,        32'h101,      0, 32'd2,        32'd14,       1};
    vecs[11] = '{5'b01111, 32'hFFFFFFFF, 32'd2,        0, 4, 32'd1,        32'hFFFFFFFE, 0, 32'd1,        32'hFFFFFFFE, 0};
    vecs[12] = '{5'b11011, 32'd0,        32'h100,      0, 0, 32'd0,        32'd0,        1, 32'd1,        32'hFFFFFFFE, 0};
    vecs[13] = '{5'b11100, 32'd9,        32'd4,        0, 1, 32'd0,        32'd5,        0, 32'd1,        32'hFFFFFFFE, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset rsp", {rsp_valid, rsp_err, rsp_hi, rsp_lo[29:0]}, 64'd0);
    chk("reset alu", {alu_y, alu_b[25:0], alu_opcode, alu_incpc}, 64'd0);
    chk("reset hi/lo", {hi_reg, lo_reg}, 64'd0);
    @(negedge clk);
    clr = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Response held under back-pressure; requests during DONE are ignored.
    @(negedge clk);
    req_opcode = 5'b00011; req_y = 32'd1; req_b = 32'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("stall rsp_valid", 64'(rsp_valid), 64'd1);
    req_valid = 1'b1; req_opcode = 5'b00100; req_y = 32'd99; req_b = 32'd98;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall c%0d valid/ready", k), {62'd0, rsp_valid, req_ready}, 64'b10);
      chk($sformatf("stall c%0d rsp", k), {rsp_err, rsp_hi[30:0], rsp_lo}, 64'd3);
      chk($sformatf("stall c%0d alu_y", k), 64'(alu_y), 64'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("release no accept", {62'd0, rsp_valid, req_ready}, 64'b01);
    chk("release alu_opcode", 64'(alu_opcode), 64'(5'b00011));

    // Reset aborts a divide two cycles into EXEC.
    @(negedge clk);
    req_opcode = 5'b10000; req_y = 32'd100; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk("abort req_ready", 64'(req_ready), 64'd1);
    chk("abort rsp", {rsp_valid, rsp_err, rsp_hi, rsp_lo[29:0]}, 64'd0);
    chk("abort alu", {alu_y, alu_b[25:0], alu_opcode, alu_incpc}, 64'd0);
    chk("abort hi/lo", {hi_reg, lo_reg}, 64'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort c%0d rsp_valid", k), 64'(rsp_valid), 64'd0);
    end
    run_vec('{5'b00011, 32'd5, 32'd7, 0, 1, 32'd0, 32'd12, 0, 32'd0, 32'd0, 0}, "post-abort add");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter MULDIV_WAIT, default 4, giving the EXEC cycles spent before capturing mul/div results (legal 1..15).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with ports listed as follows.
- clk, input, 1: the single clock, rising edge.
- clr, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request offered.
- req_ready, output, 1: block can accept a request.
- req_opcode, input, 5: CPU opcode (ld=00000 … add=00011, sub=00100, mul=01111, div=10000, branch=10011, mfhi=11000, mflo=11001, subi=11100).
- req_y, input, 32: first operand (Y side).
- req_b, input, 32: second operand (B side).
- req_incpc, input, 1: PC-increment request.
- req_br, input, 1: branch-taken flag.
- rsp_valid, output, 1: result available.
- rsp_ready, input, 1: consumer takes the result.
- rsp_hi, output, 32: captured HI.
- rsp_lo, output, 32: captured LO.
- rsp_err, output, 1: unsupported opcode or divide by zero.
- alu_y, output, 32: ALU operand drive.
- alu_b, output, 32: ALU operand drive.
- alu_opcode, output, 5: ALU opcode drive.
- alu_incpc, output, 1: ALU IncPC drive.
- alu_br, output, 1: ALU br_flag drive.
- alu_hi, input, 32: combinational HI result from the ALU.
- alu_lo, input, 32: combinational LO result from the ALU.
- hi_reg, output, 32: architectural HI register.
- lo_reg, output, 32: architectural LO register.

Function
REQ-003 The block SHALL implement states IDLE, EXEC and DONE; req_ready SHALL be 1 only in IDLE.
REQ-004 On the accept edge (IDLE and req_valid), the block SHALL register req_y, req_b, req_opcode, req_incpc and req_br into the alu_* outputs, which hold until the next accept.
REQ-005 For an accepted request with req_incpc=1 or an ALU opcode (ld, ldi, st, add..ori, neg, not, branch, subi), the block SHALL enter EXEC with count 0.
REQ-006 For accepted mul, and for accepted div with req_b≠0, the block SHALL enter EXEC with count MULDIV_WAIT-1.
REQ-007 In EXEC, each edge SHALL decrement count; at an edge with count=0 the block SHALL capture alu_hi/alu_lo into rsp_hi/rsp_lo, set rsp_err=0, and go to DONE.
REQ-008 The latency SHALL be that rsp_valid rises exactly 1 cycle after the accept edge for simple ops and MULDIV_WAIT cycles after it for mul/div.
REQ-009 alu_incpc SHALL equal the registered req_incpc only while in EXEC, and 0 otherwise; req_incpc=1 SHALL override the opcode classification.
REQ-010 For mfhi/mflo, the block SHALL skip EXEC and go to DONE on the accept edge with rsp_lo=hi_reg (mfhi) or lo_reg (mflo), rsp_hi=0 and rsp_err=0.
REQ-011 For div with req_b=0 and for jr, jal, in, out, nop, halt and undefined codes (11101–11111), the block SHALL go directly to DONE with rsp_hi=rsp_lo=0 and rsp_err=1.
REQ-012 hi_reg/lo_reg SHALL load the captured alu_hi/alu_lo only on EXEC capture of mul or div; they SHALL be unchanged by errored divides and all other operations.
REQ-013 rsp_valid SHALL be 1 exactly in DONE, with rsp_hi, rsp_lo and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-014 DONE SHALL go to IDLE on an edge with rsp_ready=1; no request is accepted on that same edge, so the minimum spacing between accepts is 3 cycles for simple ops.
REQ-015 req_valid while not in IDLE SHALL have no effect, and request inputs SHALL be sampled only on the accept edge.
REQ-016 The block SHALL not modify alu_hi/alu_lo values; the result width is 32 bits each, with no truncation or extension.

Reset
REQ-017 While clr=0, asynchronously and regardless of state (including mid-EXEC), the block SHALL force state=IDLE, count=0, and all outputs except req_ready (rsp_*, alu_*, hi_reg, lo_reg) to 0.
REQ-018 While clr=0 and afterward in IDLE, req_ready SHALL be 1; the first accept is possible on the first rising edge with clr=1.
REQ-019 An operation aborted by reset SHALL produce no response, and hi_reg/lo_reg SHALL read 0 afterward.

Verification
REQ-020 The bench SHALL check: add, Y=5, B=7, ALU model attached -> rsp_valid 1 cycle after accept, rsp_lo=12, rsp_hi=0, rsp_err=0.
REQ-021 The bench SHALL check: mul, Y=0x00010000, B=0x00010000, MULDIV_WAIT=4 -> rsp_valid 4 cycles after accept, rsp_hi=1, rsp_lo=0, hi_reg=1; then mfhi -> rsp_lo=1 on the cycle after accept.
REQ-022 The bench SHALL check: div, Y=100, B=0 -> DONE on the cycle after accept, rsp_err=1, rsp_hi=rsp_lo=0, hi_reg/lo_reg unchanged from prior values.
REQ-023 The bench SHALL check: rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_* stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle, req_ready=1.
REQ-024 The bench SHALL check: clr pulsed low 2 cycles into a MULDIV_WAIT=4 div -> rsp_valid never rises, all outputs 0, req_ready=1, and the next add accepts normally.
REQ-025 The bench SHALL check: req_incpc=1, req_b=0x100, opcode=halt -> alu_incpc=1 for exactly one cycle, rsp_lo=0x101 (ALU IncPC adds 1), rsp_err=0.
